branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined core. It replaces the static "always not-taken, resolve in EX, flush IF/ID" policy. IF looks up the current PC in a direct-mapped branch-target buffer (BTB) with 2-bit saturating counters and receives a predicted next PC. EX reports each resolved branch or jump back to the predictor, which trains the table, flags mispredictions, supplies the redirect PC to the hazard logic, and keeps saturating performance counters.

## Interface
Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 16, BTB entries; power of two ≥2. IDX_BITS = log2(ENTRIES); TAG_BITS = XLEN − IDX_BITS.
- PC_STEP, 1, sequential PC increment (core uses word addressing).
- CNT_W, 16, performance counter width.

Ports (clock and reset first; one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- enable  in  1  1 = dynamic prediction; 0 = static not-taken mode (training continues).
- PC_IF  in  XLEN  fetch PC to look up.
- predTaken_IF  out  1  predict taken.
- predTarget_IF  out  XLEN  predicted next PC.
- update_EX  in  1  a branch or jump is resolving in EX this cycle.
- updatePC_EX  in  XLEN  PC of the resolving instruction.
- updateIsJump_EX  in  1  instruction is an unconditional jump.
- updateTaken_EX  in  1  actual outcome.
- updateTarget_EX  in  XLEN  actual target.
- predTaken_EX  in  1  prediction made for this instruction, piped IF→EX.
- predTarget_EX  in  XLEN  predicted target, piped IF→EX.
- mispredict_EX  out  1  flush request.
- redirectPC_EX  out  XLEN  correct next PC.
- perfBranches  out  CNT_W  resolved branch/jump count.
- perfMispredicts  out  CNT_W  mispredict count.

## Operation
- Entry fields: valid, tag, target[XLEN], ctr[2]. Index = PC[IDX_BITS-1:0]; tag = PC[XLEN-1:IDX_BITS].
- Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is combinational from table state.
  - Hit = valid && tag match.
  - predTaken_IF = enable && rst && hit && ctr[1].
  - predTarget_IF = entry target when predTaken_IF = 1, else PC_IF + PC_STEP (modulo 2^XLEN).
- Update applies only when update_EX = 1 and rst = 1.
  - Hit, jump: ctr ← ST; target ← updateTarget_EX.
  - Hit, branch: taken → ctr saturating increment, target ← updateTarget_EX; not taken → saturating decrement, target unchanged.
  - Miss, taken: allocate the entry (overwrites any alias): valid ← 1, tag ← updatePC_EX tag, target ← updateTarget_EX, ctr ← ST for a jump, WT for a branch.
  - Miss, not taken: no change.
- mispredict_EX = update_EX && (predTaken_EX ≠ updateTaken_EX || (updateTaken_EX && predTarget_EX ≠ updateTarget_EX)).
- redirectPC_EX = updateTaken_EX ? updateTarget_EX : updatePC_EX + PC_STEP. It is meaningful only when mispredict_EX = 1.
- perfBranches increments on update_EX. perfMispredicts increments on mispredict_EX. Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- Lookup latency 0 cycles; predTaken_IF, predTarget_IF, mispredict_EX and redirectPC_EX are combinational outputs.
- Table and counter writes take effect at the rising edge; the new value is visible to lookups in the following cycle.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. No bypass.
- Reset (rst = 0 at an edge):
  - all valid ← 0, all ctr ← WNT, targets don't-care, perf counters ← 0.
  - An update presented in the reset cycle is discarded.
  - While rst = 0: predTaken_IF = 0, predTarget_IF = PC_IF + PC_STEP, mispredict_EX = 0.
  - Reset asserted mid-training wipes all learned state.
- enable deasserted: the predictor behaves as the static core. mispredict_EX still reflects predTaken_EX, which then arrives as 0.
- No stall input. The pipeline must not present the same resolving instruction twice; EX flush sets update_EX = 0.

## Structure
- Shared package holds:
  - counter encodings SNT/WNT/WT/ST.
  - PC_STEP default.
  - a function computing IDX_BITS from ENTRIES.
- Sub-module sat_counter2: combinational 2-bit next-state function.
  - Inputs: ctr, taken, force_st.
  - Output: next ctr.
  - Instantiated once in the update path.
- Table is a register array with per-entry valid, not a RAM macro, so the reset clear completes in one cycle.

## Test plan
- Reset, then PC_IF=0x20 → predTaken_IF=0, predTarget_IF=0x21; perfBranches=perfMispredicts=0.
- Update PC 0x20, branch taken, target 0x08, predTaken_EX=0 → mispredict_EX=1, redirectPC_EX=0x08 that cycle; next cycle PC_IF=0x20 gives predTaken_IF=1, target 0x08; PC_IF=0x30 (same index, different tag) gives predTaken_IF=0, target 0x31.
- Two not-taken updates on 0x20 with predTaken_EX=1 → ctr WT→WNT→SNT; first update asserts mispredict_EX with redirectPC_EX=0x21; prediction becomes not-taken after the first update.
- Jump at 0x05 → target 0x40 allocates ST; enable=0 → predTaken_IF=0; enable=1 → taken, 0x40. Same-cycle update of a different target shows 0x40 that cycle and the new target next cycle.
- CNT_W=4, 20 consecutive mispredicting updates → perfBranches=perfMispredicts=15 (saturated).
- Train 3 entries, then drive rst=0 for 1 cycle alongside an update → all lookups miss afterwards, the update is not applied, and the counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor: counter encodings,
// default sequential PC step and index-width helper.
package branch_predictor_pkg;

    // 2-bit saturating counter states; MSB set means predict taken.
    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_e;

    // Core uses word addressing, so the next sequential PC is PC + 1.
    localparam int unsigned PC_STEP_DEFAULT = 1;

    // Number of index bits for a direct-mapped table of the given size.
    function automatic int unsigned calc_idx_bits(input int unsigned entries);
        int unsigned bits;
        bits = 0;
        while ((32'd1 << bits) < entries) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    input  logic       force_st_i,
    output logic [1:0] ctr_o
);

    // Jumps pin the counter to strongly-taken; branches step toward the outcome.
    always_comb begin
        ctr_o = ctr_i;
        if (force_st_i) begin
            ctr_o = CtrSt;
        end else if (taken_i) begin
            if (ctr_i != CtrSt) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != CtrSnt) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, EX-side
// training, misprediction/redirect generation and saturating perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [XLEN-1:0]  PC_IF,
    output logic             predTaken_IF,
    output logic [XLEN-1:0]  predTarget_IF,
    input  logic             update_EX,
    input  logic [XLEN-1:0]  updatePC_EX,
    input  logic             updateIsJump_EX,
    input  logic             updateTaken_EX,
    input  logic [XLEN-1:0]  updateTarget_EX,
    input  logic             predTaken_EX,
    input  logic [XLEN-1:0]  predTarget_EX,
    output logic             mispredict_EX,
    output logic [XLEN-1:0]  redirectPC_EX,
    output logic [CNT_W-1:0] perfBranches,
    output logic [CNT_W-1:0] perfMispredicts
);

    localparam int unsigned IDX_BITS = calc_idx_bits(ENTRIES);
    localparam int unsigned TAG_BITS = XLEN - IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [CNT_W-1:0] branches_q, branches_d;
    logic [CNT_W-1:0] mispredicts_q, mispredicts_d;

    logic [IDX_BITS-1:0] idx_if, idx_ex;
    logic [TAG_BITS-1:0] tag_if, tag_ex;
    logic                hit_if, hit_ex;
    logic                upd_en;
    logic                entry_we, target_we;
    logic [1:0]          ctr_cur, ctr_nxt;

    assign idx_if = PC_IF[IDX_BITS-1:0];
    assign tag_if = PC_IF[XLEN-1:IDX_BITS];
    assign idx_ex = updatePC_EX[IDX_BITS-1:0];
    assign tag_ex = updatePC_EX[XLEN-1:IDX_BITS];

    // Fetch-side lookup; reads pre-update table contents (no bypass).
    always_comb begin
        hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
        predTaken_IF  = enable && rst && hit_if && ctr_q[idx_if][1];
        predTarget_IF = predTaken_IF ? target_q[idx_if] : PC_IF + XLEN'(PC_STEP);
    end

    // Resolution-side decode: hit detection and which fields to write.
    always_comb begin
        upd_en    = update_EX && rst;
        hit_ex    = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
        // A fresh allocation starts from WNT so a taken branch lands on WT.
        ctr_cur   = hit_ex ? ctr_q[idx_ex] : CtrWnt;
        entry_we  = upd_en && (hit_ex || updateTaken_EX);
        target_we = upd_en && (updateTaken_EX || (hit_ex && updateIsJump_EX));
    end

    sat_counter2 u_sat_counter2 (
        .ctr_i      (ctr_cur),
        .taken_i    (updateTaken_EX),
        .force_st_i (updateIsJump_EX),
        .ctr_o      (ctr_nxt)
    );

    // Flush request and the correct next PC for the hazard logic.
    always_comb begin
        mispredict_EX = rst && update_EX &&
                        ((predTaken_EX != updateTaken_EX) ||
                         (updateTaken_EX && (predTarget_EX != updateTarget_EX)));
        redirectPC_EX = updateTaken_EX ? updateTarget_EX
                                       : updatePC_EX + XLEN'(PC_STEP);
    end

    // Saturating performance counter next-state.
    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (update_EX && (branches_q != {CNT_W{1'b1}})) begin
            branches_d = branches_q + 1'b1;
        end
        if (mispredict_EX && (mispredicts_q != {CNT_W{1'b1}})) begin
            mispredicts_d = mispredicts_q + 1'b1;
        end
    end

    // Valid/counter state and perf counters; cleared in one cycle on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CtrWnt;
            end
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (entry_we) begin
                valid_q[idx_ex] <= 1'b1;
                ctr_q[idx_ex]   <= ctr_nxt;
            end
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    // Tags and targets are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (entry_we) begin
            tag_q[idx_ex] <= tag_ex;
        end
        if (target_we) begin
            target_q[idx_ex] <= updateTarget_EX;
        end
    end

    assign perfBranches    = branches_q;
    assign perfMispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, hand
// sequences for saturation and reset, and random traffic against a model.
module tb_branch_predictor;

    localparam int NENT = 16;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] pc_if;
    logic        ptaken_if, ptaken_if4;
    logic [31:0] ptarget_if, ptarget_if4;
    logic        update;
    logic [31:0] upc;
    logic        isjump;
    logic        taken;
    logic [31:0] utarget;
    logic        ptaken_ex;
    logic [31:0] ptarget_ex;
    logic        misp, misp4;
    logic [31:0] redir, redir4;
    logic [15:0] perf_b, perf_m;
    logic [3:0]  perf_b4, perf_m4;

    int errors = 0;
    int checks = 0;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .PC_IF           (pc_if),
        .predTaken_IF    (ptaken_if),
        .predTarget_IF   (ptarget_if),
        .update_EX       (update),
        .updatePC_EX     (upc),
        .updateIsJump_EX (isjump),
        .updateTaken_EX  (taken),
        .updateTarget_EX (utarget),
        .predTaken_EX    (ptaken_ex),
        .predTarget_EX   (ptarget_ex),
        .mispredict_EX   (misp),
        .redirectPC_EX   (redir),
        .perfBranches    (perf_b),
        .perfMispredicts (perf_m)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .PC_IF           (pc_if),
        .predTaken_IF    (ptaken_if4),
        .predTarget_IF   (ptarget_if4),
        .update_EX       (update),
        .updatePC_EX     (upc),
        .updateIsJump_EX (isjump),
        .updateTaken_EX  (taken),
        .updateTarget_EX (utarget),
        .predTaken_EX    (ptaken_ex),
        .predTarget_EX   (ptarget_ex),
        .mispredict_EX   (misp4),
        .redirectPC_EX   (redir4),
        .perfBranches    (perf_b4),
        .perfMispredicts (perf_m4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a table of entries with integer confidence 0..3.
    bit          m_valid  [NENT];
    logic [31:0] m_tag    [NENT];
    logic [31:0] m_target [NENT];
    int          m_conf   [NENT];
    int          m_pb, m_pm, m_pb4, m_pm4;
    logic        e_tk;
    logic [31:0] e_tg;
    logic        e_misp;
    logic [31:0] e_redir;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_expect();
        int  idx;
        bit  hit;
        idx = int'(pc_if % NENT);
        hit = m_valid[idx] && (m_tag[idx] == pc_if / NENT);
        e_tk = enable && rst && hit && (m_conf[idx] >= 2);
        e_tg = e_tk ? m_target[idx] : pc_if + 1;
        e_misp = rst && update &&
                 ((ptaken_ex != taken) || (taken && (ptarget_ex != utarget)));
        e_redir = taken ? utarget : upc + 1;
    endtask

    task automatic model_commit();
        int idx;
        bit hit;
        if (!rst) begin
            for (int i = 0; i < NENT; i++) begin
                m_valid[i] = 0;
                m_conf[i]  = 1;
            end
            m_pb = 0; m_pm = 0; m_pb4 = 0; m_pm4 = 0;
            return;
        end
        if (!update) return;
        idx = int'(upc % NENT);
        hit = m_valid[idx] && (m_tag[idx] == upc / NENT);
        if (hit) begin
            if (isjump) begin
                m_conf[idx] = 3;
                m_target[idx] = utarget;
            end else if (taken) begin
                m_conf[idx] = (m_conf[idx] < 3) ? m_conf[idx] + 1 : 3;
                m_target[idx] = utarget;
            end else begin
                m_conf[idx] = (m_conf[idx] > 0) ? m_conf[idx] - 1 : 0;
            end
        end else if (taken) begin
            m_valid[idx]  = 1;
            m_tag[idx]    = upc / NENT;
            m_target[idx] = utarget;
            m_conf[idx]   = isjump ? 3 : 2;
        end
        m_pb  = (m_pb  < 65535) ? m_pb + 1  : 65535;
        m_pb4 = (m_pb4 < 15)    ? m_pb4 + 1 : 15;
        if (e_misp) begin
            m_pm  = (m_pm  < 65535) ? m_pm + 1  : 65535;
            m_pm4 = (m_pm4 < 15)    ? m_pm4 + 1 : 15;
        end
    endtask

    // Compare DUT outputs to the model mid-cycle, then clock both.
    task automatic cycle(input string tag);
        #1;
        model_expect();
        check({tag, ".predTaken_IF"},  {31'd0, ptaken_if},  {31'd0, e_tk});
        check({tag, ".predTarget_IF"}, ptarget_if,          e_tg);
        check({tag, ".mispredict"},    {31'd0, misp},       {31'd0, e_misp});
        if (e_misp) check({tag, ".redirectPC"}, redir, e_redir);
        check({tag, ".perfBranches"},  {16'd0, perf_b},     32'(m_pb));
        check({tag, ".perfMisp"},      {16'd0, perf_m},     32'(m_pm));
        check({tag, ".perfBranches4"}, {28'd0, perf_b4},    32'(m_pb4));
        check({tag, ".perfMisp4"},     {28'd0, perf_m4},    32'(m_pm4));
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input logic r, input logic en, input logic [31:0] pc,
                         input logic u, input logic [31:0] up, input logic j,
                         input logic t, input logic [31:0] tg, input logic pt,
                         input logic [31:0] ptg);
        rst = r; enable = en; pc_if = pc; update = u; upc = up; isjump = j;
        taken = t; utarget = tg; ptaken_ex = pt; ptarget_ex = ptg;
    endtask

    task automatic do_reset();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset0");
        cycle("reset1");
    endtask

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        u;
        logic [31:0] up;
        logic        j;
        logic        t;
        logic [31:0] tg;
        logic        pt;
        logic [31:0] ptg;
        logic        x_tk;
        logic [31:0] x_tg;
        logic        x_misp;
        logic [31:0] x_redir;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1, 32'h20, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 0, 32'h21, 0, 32'h01};
        vecs[1]  = '{1, 32'h20, 1, 32'h20, 0, 1, 32'h08, 0, 32'h21, 0, 32'h21, 1, 32'h08};
        vecs[2]  = '{1, 32'h20, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 1, 32'h08, 0, 32'h01};
        vecs[3]  = '{1, 32'h30, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 0, 32'h31, 0, 32'h01};
        vecs[4]  = '{1, 32'h20, 1, 32'h20, 0, 0, 32'h00, 1, 32'h08, 1, 32'h08, 1, 32'h21};
        vecs[5]  = '{1, 32'h20, 1, 32'h20, 0, 0, 32'h00, 0, 32'h21, 0, 32'h21, 0, 32'h21};
        vecs[6]  = '{1, 32'h20, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 0, 32'h21, 0, 32'h01};
        vecs[7]  = '{1, 32'h05, 1, 32'h05, 1, 1, 32'h40, 0, 32'h06, 0, 32'h06, 1, 32'h40};
        vecs[8]  = '{0, 32'h05, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 0, 32'h06, 0, 32'h01};
        vecs[9]  = '{1, 32'h05, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 1, 32'h40, 0, 32'h01};
        vecs[10] = '{1, 32'h05, 1, 32'h05, 1, 1, 32'h50, 1, 32'h40, 1, 32'h40, 1, 32'h50};
        vecs[11] = '{1, 32'h05, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 1, 32'h50, 0, 32'h01};
        vecs[12] = '{1, 32'h20, 1, 32'h20, 0, 0, 32'h00, 0, 32'h21, 0, 32'h21, 0, 32'h21};
        vecs[13] = '{1, 32'h20, 1, 32'h20, 0, 1, 32'h08, 0, 32'h21, 0, 32'h21, 1, 32'h08};
        vecs[14] = '{1, 32'h20, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 0, 32'h21, 0, 32'h01};
        vecs[15] = '{1, 32'h05, 1, 32'h05, 0, 1, 32'h50, 1, 32'h50, 1, 32'h50, 0, 32'h50};
        vecs[16] = '{1, 32'h05, 1, 32'h05, 0, 0, 32'h00, 1, 32'h50, 1, 32'h50, 1, 32'h06};
        vecs[17] = '{1, 32'h05, 0, 32'h00, 0, 0, 32'h00, 0, 32'h00, 1, 32'h50, 0, 32'h01};

        do_reset();

        // Directed table: constants from hand derivation, model kept in step.
        for (int i = 0; i < 18; i++) begin
            drive(1, vecs[i].en, vecs[i].pc, vecs[i].u, vecs[i].up, vecs[i].j,
                  vecs[i].t, vecs[i].tg, vecs[i].pt, vecs[i].ptg);
            #1;
            check($sformatf("vec%0d.tk", i),  {31'd0, ptaken_if}, {31'd0, vecs[i].x_tk});
            check($sformatf("vec%0d.tg", i),  ptarget_if,         vecs[i].x_tg);
            check($sformatf("vec%0d.mp", i),  {31'd0, misp},      {31'd0, vecs[i].x_misp});
            check($sformatf("vec%0d.rd", i),  redir,              vecs[i].x_redir);
            cycle($sformatf("vec%0d", i));
        end
        check("table.perfBranches", {16'd0, perf_b}, 32'd9);
        check("table.perfMisp",     {16'd0, perf_m}, 32'd6);

        // Perf saturation: 20 consecutive mispredicts.
        do_reset();
        check("rst.perfBranches", {16'd0, perf_b}, 32'd0);
        check("rst.perfMisp",     {16'd0, perf_m}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 32'h100, 1, 32'h100 + i, 0, 1, 32'h200, 0, 32'h0);
            cycle("sat");
        end
        drive(1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("sat.perfBranches4", {28'd0, perf_b4}, 32'd15);
        check("sat.perfMisp4",     {28'd0, perf_m4}, 32'd15);
        check("sat.perfBranches",  {16'd0, perf_b},  32'd20);
        check("sat.perfMisp",      {16'd0, perf_m},  32'd20);

        // Reset mid-training wipes state and drops a concurrent update.
        do_reset();
        drive(1, 1, 32'h0, 1, 32'h11, 0, 1, 32'h91, 0, 32'h12); cycle("train1");
        drive(1, 1, 32'h0, 1, 32'h22, 0, 1, 32'h92, 0, 32'h23); cycle("train2");
        drive(1, 1, 32'h0, 1, 32'h33, 1, 1, 32'h93, 0, 32'h34); cycle("train3");
        drive(1, 1, 32'h22, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("trained.tk", {31'd0, ptaken_if}, 32'd1);
        check("trained.tg", ptarget_if, 32'h92);
        drive(0, 1, 32'h11, 1, 32'h44, 0, 1, 32'h99, 0, 32'h45);
        #1;
        check("inrst.tk", {31'd0, ptaken_if}, 32'd0);
        check("inrst.tg", ptarget_if, 32'h12);
        check("inrst.mp", {31'd0, misp}, 32'd0);
        cycle("inrst");
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 32'(i * 32'h11), 0, 0, 0, 0, 0, 0, 0);
            #1;
            check($sformatf("wiped%0d.tk", i), {31'd0, ptaken_if}, 32'd0);
            check($sformatf("wiped%0d.tg", i), ptarget_if, 32'(i * 32'h11 + 1));
            cycle("wiped");
        end

        // Random traffic over a small PC pool so entries alias and hit.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p, q;
            logic        tk;
            logic [31:0] tg;
            p = (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            q = (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0), q,
                  $urandom_range(0, 1), p, ($urandom_range(0, 4) == 0),
                  $urandom_range(0, 1), 32'($urandom_range(0, 7)) << 3, 0, 0);
            if (isjump) taken = 1'b1;
            // Emulate the prediction made in IF for the resolving PC.
            pc_if = p;
            #1;
            model_expect();
            tk = e_tk;
            tg = e_tg;
            if ($urandom_range(0, 9) == 0) begin
                tk = ~tk;
                tg = tg ^ 32'h8;
            end
            ptaken_ex = tk;
            ptarget_ex = tg;
            pc_if = q;
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
